hough_peak_select: RTL and testbench
====================================

# hough_peak_select

Scans the completed Hough accumulator buffer, one BRAM word (THETA_UNROLL adjacent theta bins of one rho) per cycle. Finds the strongest line in the left-lane theta window and the strongest in the right-lane theta window. Sits between the accumulator fill stage and the line-draw stage: it starts on accumulator-done and hands signed rho/theta pairs to the drawer.

## Interface
- RHOS, 1469: rho offset; rho_index − RHOS gives signed rho
- RHO_RANGE, 2938: number of rho indices (2*RHOS)
- THETAS, 180: theta bins, 0..179 degrees
- THETA_UNROLL, 4: bins per BRAM word; THETAS % THETA_UNROLL == 0
- ACCUM_BUFF_WIDTH, 16: vote counter width
- THETA_BITS, 8: theta output width
- LEFT_THETA_MIN / LEFT_THETA_MAX, 91 / 179: inclusive left-lane window
- RIGHT_THETA_MIN / RIGHT_THETA_MAX, 1 / 89: inclusive right-lane window
- MIN_VOTES, 20: a bin qualifies only if votes ≥ MIN_VOTES
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle pulse; begins a scan when idle
- accum_rd_addr  out  clog2(RHO_RANGE*THETAS/THETA_UNROLL)  word address = rho_idx*(THETAS/THETA_UNROLL) + group
- accum_rd_data  in  THETA_UNROLL*ACCUM_BUFF_WIDTH  lane k (bits [k*W +: W]) = theta group*THETA_UNROLL + k; valid one cycle after the address
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when results are final
- left_valid / right_valid  out  1  a qualifying bin was found in the window
- left_rho / right_rho  out  16 signed  best rho
- left_theta / right_theta  out  THETA_BITS  best theta
- left_votes / right_votes  out  ACCUM_BUFF_WIDTH  winning vote count

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE, start=1: clear the running bests (votes 0, valid 0, rho/theta 0). Go to READ; accum_rd_addr = 0 in the first READ cycle.
- READ: addr increments by 1 each cycle. After issuing the last address N−1 (N = RHO_RANGE*THETAS/THETA_UNROLL = 132210), go to DRAIN.
- DRAIN: processes the final word's data. Go to DONE.
- DONE: done=1 for one cycle. Go to IDLE.
- Data pipeline: register the (rho_idx, group) of each issued address one stage to align with accum_rd_data. Each lane's theta = group*THETA_UNROLL + k.
- Per-window compare, done independently for left and right:
  - A lane is a candidate if its theta is inside the window and its votes ≥ MIN_VOTES.
  - Reduce candidates across lanes; on equal votes the lower lane wins.
  - Update the running best only if the lane winner's votes > best votes (strict). Earliest in scan order therefore wins ties: lower rho_idx, then lower theta.
- Output rho = rho_idx − RHOS, computed as signed 16-bit.
- All outputs are registered. Results hold from DONE until the next accepted start.
- start while busy: ignored.
- Window with no qualifying bin: valid=0, rho=0, theta=0, votes=0.
- THETA_UNROLL lanes may straddle a window edge; each lane is tested individually.

## Timing
- Reset (async, active-low): state IDLE, accum_rd_addr=0, busy=0, done=0, and every result output 0.
- Reset mid-scan aborts the scan: outputs return to reset values and no done pulse is produced.
- start sampled at cycle 0 → addr 0 presented at cycle 1 → addr N−1 at cycle N → DRAIN at cycle N+1 → done=1 at cycle N+2. This is N+2 cycles of latency, 132212 for the defaults.
- busy=1 from cycle 1 through cycle N+1; it is low in the done cycle.
- Result outputs are final and stable in the done cycle.
- Read-port latency is fixed at 1 cycle; no back-pressure.

## Test plan
- All-zero accumulator, start → done at cycle 132212; left_valid=right_valid=0; all rho/theta/votes = 0.
- Peaks:
  - Stimulus: votes 500 at (rho_idx 1306, theta 128); votes 300 at (rho_idx 2044, theta 60); 10 elsewhere.
  - Required: left_rho=−163, left_theta=128, left_votes=500; right_rho=575, right_theta=60, right_votes=300.
- Out-of-window large values:
  - Stimulus: 900 votes at theta 0, 90 and 180-boundary lane 179 (in window); 50 at (rho_idx 0, theta 45).
  - Required: left_theta=179, left_votes=900; right_rho=−1469, right_theta=45, right_votes=50. Thetas 0 and 90 never win.
- Ties:
  - Stimulus: 200 votes at (rho_idx 100, theta 130), (rho_idx 100, theta 129) and (rho_idx 50, theta 170).
  - Required: left_rho=50−1469=−1419, left_theta=170.
  - Same vote count within one word at thetas 128 and 129 → theta 128.
- Threshold: single left bin at 19 votes → left_valid=0. Change it to 20 → left_valid=1.
- Control:
  - start pulsed again at cycle 1000 → ignored; done still at cycle 132212.
  - reset asserted at cycle 5000 → busy=0 and outputs 0 immediately; no done pulse.
  - A fresh start then completes normally.

Source files
------------

// File: rtl/hough_peak_select.sv
// Scans the Hough accumulator one BRAM word per cycle and keeps the strongest
// qualifying bin inside the left-lane and right-lane theta windows.
module hough_peak_select #(
    parameter int RHOS             = 1469,
    parameter int RHO_RANGE        = 2938,
    parameter int THETAS           = 180,
    parameter int THETA_UNROLL     = 4,
    parameter int ACCUM_BUFF_WIDTH = 16,
    parameter int THETA_BITS       = 8,
    parameter int LEFT_THETA_MIN   = 91,
    parameter int LEFT_THETA_MAX   = 179,
    parameter int RIGHT_THETA_MIN  = 1,
    parameter int RIGHT_THETA_MAX  = 89,
    parameter int MIN_VOTES        = 20,
    localparam int GROUPS    = THETAS / THETA_UNROLL,
    localparam int WORDS     = RHO_RANGE * GROUPS,
    localparam int ADDR_BITS = $clog2(WORDS)
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     start,
    output logic [ADDR_BITS-1:0]                     accum_rd_addr,
    input  logic [THETA_UNROLL*ACCUM_BUFF_WIDTH-1:0] accum_rd_data,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     left_valid,
    output logic signed [15:0]                       left_rho,
    output logic [THETA_BITS-1:0]                    left_theta,
    output logic [ACCUM_BUFF_WIDTH-1:0]              left_votes,
    output logic                                     right_valid,
    output logic signed [15:0]                       right_rho,
    output logic [THETA_BITS-1:0]                    right_theta,
    output logic [ACCUM_BUFF_WIDTH-1:0]              right_votes
);
    localparam int RHO_BITS   = (RHO_RANGE > 1) ? $clog2(RHO_RANGE) : 1;
    localparam int GROUP_BITS = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state_reg;

    // rho/group counters run alongside the address so no divider is needed
    logic [RHO_BITS-1:0]   rho_cnt_reg, pipe_rho_reg;
    logic [GROUP_BITS-1:0] grp_cnt_reg, pipe_grp_reg;
    logic                  pipe_valid_reg;
    logic signed [15:0]    pipe_rho_s;

    logic [ACCUM_BUFF_WIDTH-1:0] lane_votes [THETA_UNROLL];
    logic [THETA_BITS-1:0]       lane_theta [THETA_UNROLL];
    logic [31:0]                 lane_theta_full [THETA_UNROLL];
    logic [THETA_UNROLL-1:0]     left_cand, right_cand;

    logic                        left_found, right_found;
    logic [ACCUM_BUFF_WIDTH-1:0] left_win_votes, right_win_votes;
    logic [THETA_BITS-1:0]       left_win_theta, right_win_theta;

    assign pipe_rho_s = 16'(pipe_rho_reg) - 16'(RHOS);

    for (genvar gi = 0; gi < THETA_UNROLL; gi++) begin : g_lane
        assign lane_votes[gi]      = accum_rd_data[gi*ACCUM_BUFF_WIDTH +: ACCUM_BUFF_WIDTH];
        assign lane_theta_full[gi] = 32'(pipe_grp_reg) * 32'(THETA_UNROLL) + 32'(gi);
        assign lane_theta[gi]      = THETA_BITS'(lane_theta_full[gi]);
        assign left_cand[gi]  = pipe_valid_reg
                              && lane_theta_full[gi] >= 32'(LEFT_THETA_MIN)
                              && lane_theta_full[gi] <= 32'(LEFT_THETA_MAX)
                              && lane_votes[gi] >= ACCUM_BUFF_WIDTH'(MIN_VOTES);
        assign right_cand[gi] = pipe_valid_reg
                              && lane_theta_full[gi] >= 32'(RIGHT_THETA_MIN)
                              && lane_theta_full[gi] <= 32'(RIGHT_THETA_MAX)
                              && lane_votes[gi] >= ACCUM_BUFF_WIDTH'(MIN_VOTES);
    end

    // Strict '>' keeps the lowest lane on equal votes.
    always_comb begin
        left_found      = 1'b0;
        left_win_votes  = '0;
        left_win_theta  = '0;
        right_found     = 1'b0;
        right_win_votes = '0;
        right_win_theta = '0;
        for (int k = 0; k < THETA_UNROLL; k++) begin
            if (left_cand[k] && (!left_found || lane_votes[k] > left_win_votes)) begin
                left_found     = 1'b1;
                left_win_votes = lane_votes[k];
                left_win_theta = lane_theta[k];
            end
            if (right_cand[k] && (!right_found || lane_votes[k] > right_win_votes)) begin
                right_found     = 1'b1;
                right_win_votes = lane_votes[k];
                right_win_theta = lane_theta[k];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            accum_rd_addr  <= '0;
            rho_cnt_reg    <= '0;
            grp_cnt_reg    <= '0;
            pipe_rho_reg   <= '0;
            pipe_grp_reg   <= '0;
            pipe_valid_reg <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            left_valid     <= 1'b0;
            left_rho       <= '0;
            left_theta     <= '0;
            left_votes     <= '0;
            right_valid    <= 1'b0;
            right_rho      <= '0;
            right_theta    <= '0;
            right_votes    <= '0;
        end else begin
            done           <= 1'b0;
            pipe_valid_reg <= 1'b0;
            // Strict '>' against the running best keeps the earliest bin in scan order.
            if (left_found && left_win_votes > left_votes) begin
                left_valid <= 1'b1;
                left_rho   <= pipe_rho_s;
                left_theta <= left_win_theta;
                left_votes <= left_win_votes;
            end
            if (right_found && right_win_votes > right_votes) begin
                right_valid <= 1'b1;
                right_rho   <= pipe_rho_s;
                right_theta <= right_win_theta;
                right_votes <= right_win_votes;
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg     <= READ;
                        busy          <= 1'b1;
                        accum_rd_addr <= '0;
                        rho_cnt_reg   <= '0;
                        grp_cnt_reg   <= '0;
                        left_valid    <= 1'b0;
                        left_rho      <= '0;
                        left_theta    <= '0;
                        left_votes    <= '0;
                        right_valid   <= 1'b0;
                        right_rho     <= '0;
                        right_theta   <= '0;
                        right_votes   <= '0;
                    end
                end
                READ: begin
                    pipe_valid_reg <= 1'b1;
                    pipe_rho_reg   <= rho_cnt_reg;
                    pipe_grp_reg   <= grp_cnt_reg;
                    if (accum_rd_addr == ADDR_BITS'(WORDS - 1)) begin
                        state_reg <= DRAIN;
                    end else begin
                        accum_rd_addr <= accum_rd_addr + 1'b1;
                        if (grp_cnt_reg == GROUP_BITS'(GROUPS - 1)) begin
                            grp_cnt_reg <= '0;
                            rho_cnt_reg <= rho_cnt_reg + 1'b1;
                        end else begin
                            grp_cnt_reg <= grp_cnt_reg + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    state_reg <= DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hough_peak_select.sv
// Self-checking bench for hough_peak_select on a reduced rho range; results are
// compared against a bin-by-bin scan of the accumulator image held in the bench.
module tb_hough_peak_select;
    localparam int RHOS   = 16;
    localparam int RR     = 32;
    localparam int TH     = 180;
    localparam int TU     = 4;
    localparam int W      = 16;
    localparam int TB     = 8;
    localparam int LMIN   = 91;
    localparam int LMAX   = 179;
    localparam int RMIN   = 1;
    localparam int RMAX   = 89;
    localparam int MINV   = 20;
    localparam int GROUPS = TH / TU;
    localparam int N      = RR * GROUPS;
    localparam int AW     = $clog2(N);

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [AW-1:0]      accum_rd_addr;
    logic [TU*W-1:0]    accum_rd_data = '0;
    logic               busy, done;
    logic               left_valid, right_valid;
    logic signed [15:0] left_rho, right_rho;
    logic [TB-1:0]      left_theta, right_theta;
    logic [W-1:0]       left_votes, right_votes;

    int checks = 0;
    int errors = 0;
    int mem [RR][TH];
    logic [81:0] exp_res;
    logic [81:0] res_obs;

    assign res_obs = {left_valid, left_rho, left_theta, left_votes,
                      right_valid, right_rho, right_theta, right_votes};

    hough_peak_select #(
        .RHOS(RHOS), .RHO_RANGE(RR), .THETAS(TH), .THETA_UNROLL(TU),
        .ACCUM_BUFF_WIDTH(W), .THETA_BITS(TB),
        .LEFT_THETA_MIN(LMIN), .LEFT_THETA_MAX(LMAX),
        .RIGHT_THETA_MIN(RMIN), .RIGHT_THETA_MAX(RMAX), .MIN_VOTES(MINV)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .accum_rd_addr(accum_rd_addr), .accum_rd_data(accum_rd_data),
        .busy(busy), .done(done),
        .left_valid(left_valid), .left_rho(left_rho), .left_theta(left_theta), .left_votes(left_votes),
        .right_valid(right_valid), .right_rho(right_rho), .right_theta(right_theta), .right_votes(right_votes)
    );

    always #5 clock = ~clock;

    // One-cycle-latency read port backed by the bench's accumulator image
    always @(posedge clock) begin
        automatic int a = int'(accum_rd_addr);
        for (int k = 0; k < TU; k++) begin
            if (a < N)
                accum_rd_data[k*W +: W] <= W'(mem[a / GROUPS][(a % GROUPS) * TU + k]);
            else
                accum_rd_data[k*W +: W] <= '0;
        end
    end

    task automatic fill(input int v);
        for (int r = 0; r < RR; r++)
            for (int t = 0; t < TH; t++)
                mem[r][t] = v;
    endtask

    // Reference: visit every bin in rho-major, theta-ascending order; first strict maximum wins.
    task automatic compute_expected();
        int lb, lr, lt, rb, rr, rt;
        bit lv, rv;
        lb = 0; lr = 0; lt = 0; lv = 0;
        rb = 0; rr = 0; rt = 0; rv = 0;
        for (int r = 0; r < RR; r++) begin
            for (int t = 0; t < TH; t++) begin
                if (mem[r][t] >= MINV) begin
                    if (t >= LMIN && t <= LMAX && mem[r][t] > lb) begin
                        lb = mem[r][t]; lr = r - RHOS; lt = t; lv = 1;
                    end
                    if (t >= RMIN && t <= RMAX && mem[r][t] > rb) begin
                        rb = mem[r][t]; rr = r - RHOS; rt = t; rv = 1;
                    end
                end
            end
        end
        exp_res = {lv, 16'(lr), 8'(lt), 16'(lb), rv, 16'(rr), 8'(rt), 16'(rb)};
    endtask

    // Drives one scan; lat is the done cycle counted from the start-sampling cycle, -1 on timeout.
    task automatic run_scan(input int pulse_at, output int lat, output logic busy1, output logic busy_done);
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        lat = -1; busy1 = 1'b0; busy_done = 1'b1;
        for (int c = 1; c <= N + 20; c++) begin
            if (c == 1) busy1 = busy;
            if (done) begin
                lat = c; busy_done = busy;
                break;
            end
            start = (c == pulse_at);
            @(posedge clock); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({busy, done, accum_rd_addr} !== '0 || res_obs !== '0) begin
            errors++;
            $display("FAIL reset_hold: busy=%b done=%b addr=%0d res=%h, want all 0", busy, done, accum_rd_addr, res_obs);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if ({busy, done, accum_rd_addr} !== '0 || res_obs !== '0) begin
            errors++;
            $display("FAIL reset_release: busy=%b done=%b addr=%0d res=%h, want all 0", busy, done, accum_rd_addr, res_obs);
        end
        $display("test_reset: done");
    endtask

    task automatic test_zero();
        int lat; logic b1, bd;
        fill(0);
        compute_expected();
        run_scan(0, lat, b1, bd);
        checks++;
        if (lat !== N + 2) begin
            errors++; $display("FAIL zero_latency: got %0d, want %0d", lat, N + 2);
        end
        checks++;
        if (b1 !== 1'b1 || bd !== 1'b0) begin
            errors++; $display("FAIL zero_busy: cycle1=%b done_cycle=%b, want 1/0", b1, bd);
        end
        checks++;
        if (res_obs !== exp_res || res_obs !== '0) begin
            errors++; $display("FAIL zero_results: got %h, want %h", res_obs, exp_res);
        end
        @(posedge clock); #1;
        checks++;
        if (done !== 1'b0 || res_obs !== exp_res) begin
            errors++; $display("FAIL zero_done_pulse: done=%b res=%h, want 0 / %h", done, res_obs, exp_res);
        end
        $display("test_zero: latency=%0d", lat);
    endtask

    task automatic test_scenario(input int id);
        int lat; logic b1, bd;
        string name;
        fill(0);
        case (id)
            0: begin
                name = "peaks";
                fill(10);
                mem[20][128] = 500;
                mem[28][60]  = 300;
            end
            1: begin
                name = "out_of_window";
                for (int r = 0; r < RR; r++) begin
                    mem[r][0] = 900; mem[r][90] = 900;
                end
                mem[7][179] = 900;
                mem[0][45]  = 50;
            end
            2: begin
                name = "ties_across_rho";
                mem[10][130] = 200; mem[10][129] = 200; mem[5][170] = 200;
            end
            3: begin
                name = "ties_in_word";
                mem[3][129] = 200; mem[3][128] = 200;
                mem[9][2] = 77; mem[9][1] = 77;
            end
            4: begin
                name = "threshold_19";
                mem[12][100] = MINV - 1;
                mem[4][89] = MINV - 1;
            end
            5: begin
                name = "threshold_20";
                mem[12][100] = MINV;
                mem[4][89] = MINV;
            end
            default: begin
                name = "edges";
                mem[2][91] = 40; mem[2][89] = 40; mem[2][1] = 30; mem[30][179] = 41;
            end
        endcase
        compute_expected();
        run_scan(0, lat, b1, bd);
        checks++;
        if (lat !== N + 2) begin
            errors++; $display("FAIL %s_latency: got %0d, want %0d", name, lat, N + 2);
        end
        checks++;
        if (res_obs !== exp_res) begin
            errors++; $display("FAIL %s_results: got %h, want %h", name, res_obs, exp_res);
        end
        $display("test_%s: L(v=%b rho=%0d th=%0d votes=%0d) R(v=%b rho=%0d th=%0d votes=%0d)",
                 name, left_valid, left_rho, left_theta, left_votes,
                 right_valid, right_rho, right_theta, right_votes);
    endtask

    task automatic test_random();
        int lat; logic b1, bd;
        for (int it = 0; it < 3; it++) begin
            for (int r = 0; r < RR; r++)
                for (int t = 0; t < TH; t++)
                    mem[r][t] = $urandom_range(0, 45);
            for (int p = 0; p < 4; p++)
                mem[$urandom_range(0, RR - 1)][$urandom_range(0, TH - 1)] = $urandom_range(46, 1000);
            compute_expected();
            run_scan(0, lat, b1, bd);
            checks++;
            if (lat !== N + 2 || res_obs !== exp_res) begin
                errors++; $display("FAIL random%0d: lat=%0d res=%h, want lat=%0d res=%h", it, lat, res_obs, N + 2, exp_res);
            end
            $display("test_random %0d: left_theta=%0d right_theta=%0d", it, left_theta, right_theta);
        end
    endtask

    task automatic test_start_ignored();
        int lat; logic b1, bd;
        fill(0);
        mem[15][150] = 321;
        compute_expected();
        run_scan(100, lat, b1, bd);
        checks++;
        if (lat !== N + 2 || res_obs !== exp_res) begin
            errors++; $display("FAIL start_ignored: lat=%0d res=%h, want lat=%0d res=%h", lat, res_obs, N + 2, exp_res);
        end
        $display("test_start_ignored: latency=%0d", lat);
    endtask

    task automatic test_reset_midscan();
        int lat; logic b1, bd;
        bit saw_done;
        fill(0);
        mem[0][128] = 500;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        repeat (499) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b1 || left_valid !== 1'b1) begin
            errors++; $display("FAIL midscan_pre: busy=%b left_valid=%b, want 1/1", busy, left_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, accum_rd_addr} !== '0 || res_obs !== '0) begin
            errors++; $display("FAIL midscan_reset: busy=%b done=%b addr=%0d res=%h, want all 0", busy, done, accum_rd_addr, res_obs);
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        saw_done = 0;
        for (int c = 0; c < N + 10; c++) begin
            @(posedge clock); #1;
            if (done || busy) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++; $display("FAIL midscan_no_done: saw done/busy after abort, want none");
        end
        compute_expected();
        run_scan(0, lat, b1, bd);
        checks++;
        if (lat !== N + 2 || res_obs !== exp_res) begin
            errors++; $display("FAIL fresh_start: lat=%0d res=%h, want lat=%0d res=%h", lat, res_obs, N + 2, exp_res);
        end
        $display("test_reset_midscan: fresh scan latency=%0d", lat);
    endtask

    task automatic test_back_to_back();
        int lat; logic b1, bd;
        fill(0);
        mem[25][100] = 60;
        mem[1][10] = 70;
        compute_expected();
        run_scan(0, lat, b1, bd);
        checks++;
        if (lat !== N + 2 || res_obs !== exp_res) begin
            errors++; $display("FAIL b2b_first: lat=%0d res=%h, want lat=%0d res=%h", lat, res_obs, N + 2, exp_res);
        end
        // Smaller peaks in the second scan only show up if the bests were cleared on start.
        fill(0);
        mem[30][140] = 25;
        mem[31][80] = 22;
        compute_expected();
        run_scan(0, lat, b1, bd);
        checks++;
        if (lat !== N + 2 || res_obs !== exp_res) begin
            errors++; $display("FAIL b2b_second: lat=%0d res=%h, want lat=%0d res=%h", lat, res_obs, N + 2, exp_res);
        end
        $display("test_back_to_back: left_votes=%0d right_votes=%0d", left_votes, right_votes);
    endtask

    initial begin
        fill(0);
        test_reset();
        test_zero();
        for (int s = 0; s < 7; s++) test_scenario(s);
        test_random();
        test_start_ignored();
        test_reset_midscan();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
